// File: rtl/logical_simd_unit.sv
// Multi-lane pipelined logical/select/shift/rotate unit with valid/ready handshakes.
// Each 32-bit lane runs as one 32-bit element or two independent 16-bit halves.
module logical_simd_unit #(
  parameter int LANES   = 4,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld_i,
  output logic                  in_rdy_o,
  input  logic [3:0]            op_i,
  input  logic                  prec_i,
  input  logic                  shift_dir_i,
  input  logic [LANES-1:0]      lane_en_i,
  input  logic [LANES*32-1:0]   src0_i,
  input  logic [LANES*32-1:0]   src1_i,
  input  logic [LANES*6-1:0]    cmp_status_i,
  output logic                  out_vld_o,
  input  logic                  out_rdy_i,
  output logic [LANES*32-1:0]   dst_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      op_cnt_o
);

  localparam logic [3:0] OP_AND    = 4'h0;
  localparam logic [3:0] OP_OR     = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_NOT    = 4'h3;
  localparam logic [3:0] OP_COPY   = 4'h4;
  localparam logic [3:0] OP_SEL_GT = 4'h5;
  localparam logic [3:0] OP_SEL_EQ = 4'h6;
  localparam logic [3:0] OP_SEL_LS = 4'h7;
  localparam logic [3:0] OP_LSH    = 4'h8;
  localparam logic [3:0] OP_ASH    = 4'h9;
  localparam logic [3:0] OP_ROT    = 4'hA;

  // Status triple st is {GT, EQ, LS}.
  function automatic logic [31:0] elem32(input logic [3:0] op, input logic dir,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] st);
    logic [4:0]  sh;
    logic [63:0] rot;
    logic [31:0] r;
    sh  = b[4:0];
    rot = '0;
    r   = '0;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NOT:    r = ~a;
      OP_COPY:   r = a;
      OP_SEL_GT: r = st[2] ? a : b;
      OP_SEL_EQ: r = st[1] ? a : b;
      OP_SEL_LS: r = st[0] ? a : b;
      OP_LSH:    r = dir ? (a >> sh) : (a << sh);
      OP_ASH:    r = dir ? $unsigned($signed(a) >>> sh) : (a << sh);
      OP_ROT: begin
        if (dir) begin
          rot = {a, a} >> sh;
          r   = rot[31:0];
        end else begin
          rot = {a, a} << sh;
          r   = rot[63:32];
        end
      end
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] elem16(input logic [3:0] op, input logic dir,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] st);
    logic [3:0]  sh;
    logic [31:0] rot;
    logic [15:0] r;
    sh  = b[3:0];
    rot = '0;
    r   = '0;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NOT:    r = ~a;
      OP_COPY:   r = a;
      OP_SEL_GT: r = st[2] ? a : b;
      OP_SEL_EQ: r = st[1] ? a : b;
      OP_SEL_LS: r = st[0] ? a : b;
      OP_LSH:    r = dir ? (a >> sh) : (a << sh);
      OP_ASH:    r = dir ? $unsigned($signed(a) >>> sh) : (a << sh);
      OP_ROT: begin
        if (dir) begin
          rot = {a, a} >> sh;
          r   = rot[15:0];
        end else begin
          rot = {a, a} << sh;
          r   = rot[31:16];
        end
      end
      default:   r = '0;
    endcase
    return r;
  endfunction

  // 32-bit mode looks only at the lo status triple.
  function automatic logic [31:0] lane_calc(input logic [3:0] op, input logic prec,
                                            input logic dir, input logic [31:0] a,
                                            input logic [31:0] b, input logic [5:0] st);
    logic [31:0] r;
    if (prec) begin
      r = elem32(op, dir, a, b, st[2:0]);
    end else begin
      r = {elem16(op, dir, a[31:16], b[31:16], st[5:3]),
           elem16(op, dir, a[15:0],  b[15:0],  st[2:0])};
    end
    return r;
  endfunction

  logic                  illegal;
  logic                  acc;
  logic                  xfer;
  logic [LANES*32-1:0]   res;
  logic [LATENCY-1:0]    ld;
  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [LANES*32-1:0]   dat_q [LATENCY];
  logic [LANES*32-1:0]   dat_d [LATENCY];
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign illegal = (op_i > OP_ROT);

  always_comb begin
    res = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_en_i[k] && !illegal) begin
        res[32*k +: 32] = lane_calc(op_i, prec_i, shift_dir_i, src0_i[32*k +: 32],
                                    src1_i[32*k +: 32], cmp_status_i[6*k +: 6]);
      end
    end
  end

  // ld[s]: stage s can take new content this cycle (empty, or its content moves on).
  always_comb begin : ld_chain
    logic down_ok;
    down_ok = out_rdy_i;
    ld      = '0;
    for (int s = LATENCY - 1; s >= 0; s--) begin
      ld[s]   = !vld_q[s] || down_ok;
      down_ok = ld[s];
    end
  end

  assign in_rdy_o  = ld[0] && !rst_n;
  assign acc       = in_vld_i && in_rdy_o;
  assign out_vld_o = vld_q[LATENCY-1];
  assign dst_o     = dat_q[LATENCY-1];
  assign xfer      = out_vld_o && out_rdy_i;
  assign err_o     = err_q;
  assign op_cnt_o  = cnt_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (ld[0]) begin
      vld_d[0] = acc;
      if (acc) dat_d[0] = res;
    end
    for (int s = 1; s < LATENCY; s++) begin
      if (ld[s]) begin
        vld_d[s] = vld_q[s-1];
        if (vld_q[s-1]) dat_d[s] = dat_q[s-1];
      end
    end
    err_d = err_q || (acc && illegal);
    cnt_d = cnt_q + CNT_W'(xfer);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < LATENCY; s++) dat_q[s] <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < LATENCY; s++) dat_q[s] <= dat_d[s];
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  a_out_stable: assert property (@(posedge clk) disable iff (rst_n)
    (out_vld_o && !out_rdy_i) |=> (out_vld_o && $stable(dst_o)));

endmodule

// File: tb/tb_logical_simd_unit.sv
// Scoreboard bench for logical_simd_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_logical_simd_unit;

  localparam int LANES = 4;
  localparam int LAT   = 2;
  localparam int CW    = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_vld_i = 1'b0;
  logic                in_rdy_o;
  logic [3:0]          op_i = '0;
  logic                prec_i = 1'b1;
  logic                shift_dir_i = 1'b0;
  logic [LANES-1:0]    lane_en_i = '1;
  logic [LANES*32-1:0] src0_i = '0;
  logic [LANES*32-1:0] src1_i = '0;
  logic [LANES*6-1:0]  cmp_status_i = '0;
  logic                out_vld_o;
  logic                out_rdy_i = 1'b1;
  logic [LANES*32-1:0] dst_o;
  logic                err_o;
  logic [CW-1:0]       op_cnt_o;

  logical_simd_unit #(.LANES(LANES), .LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
    .op_i(op_i), .prec_i(prec_i), .shift_dir_i(shift_dir_i), .lane_en_i(lane_en_i),
    .src0_i(src0_i), .src1_i(src1_i), .cmp_status_i(cmp_status_i),
    .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .dst_o(dst_o),
    .err_o(err_o), .op_cnt_o(op_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [127:0] exp_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n && out_vld_o && out_rdy_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", dst_o, 128'hx);
      end else begin
        chk("dst", dst_o, exp_q.pop_front());
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [3:0] op, input logic prec, input logic dir,
                      input logic [3:0] en, input logic [127:0] s0, input logic [127:0] s1,
                      input logic [23:0] st, input logic [127:0] exp);
    bit got;
    got = 0;
    op_i = op; prec_i = prec; shift_dir_i = dir; lane_en_i = en;
    src0_i = s0; src1_i = s1; cmp_status_i = st;
    in_vld_i = 1'b1;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (in_rdy_o) got = 1;
    end
    if (got) begin
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
    end else begin
      chk("send_timeout", 128'(in_rdy_o), 128'(1));
      @(posedge clk);
      #1;
    end
    in_vld_i = 1'b0;
    src0_i = {4{32'hDEAD_DEAD}};
    src1_i = {4{32'h0BAD_0BAD}};
    cmp_status_i = '1;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  function automatic logic [127:0] bp_vec(input int i);
    return {32'hA0A0_0000 + 32'(i), 32'hB0B0_0000 + 32'(i),
            32'hC0C0_0000 + 32'(i), 32'hD0D0_0000 + 32'(i)};
  endfunction

  localparam logic [127:0] V_A = {32'hFFFF_0000, 32'h1234_5678, 32'h0F0F_0F0F, 32'hDEAD_BEEF};
  localparam logic [127:0] V_B = {32'h00FF_FF00, 32'hFFFF_0000, 32'hFF00_FF00, 32'hFFFF_FFFF};

  initial begin
    int accepts;
    bit seen_vld;

    // reset held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", 128'(in_rdy_o), 128'(0));
    chk("rst_out_vld", 128'(out_vld_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    chk("rst_cnt", 128'(op_cnt_o), 128'(0));
    chk("rst_dst", dst_o, 128'(0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // rotate, with latency check on the first result
    send(4'hA, 1, 0, 4'hF, {4{32'h1234_5678}}, {4{32'h8}}, '0, {4{32'h3456_7812}});
    @(negedge clk);
    chk("lat_not_yet", 128'(out_vld_o), 128'(0));
    @(negedge clk);
    chk("lat_arrive", 128'(out_vld_o), 128'(1));
    @(posedge clk);
    #1;
    send(4'hA, 1, 1, 4'hF, {4{32'h1234_5678}}, {4{32'h8}}, '0, {4{32'h7812_3456}});
    wait_drain();
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("idle_out_vld", 128'(out_vld_o), 128'(0));
    @(posedge clk);
    #1;

    // 16-bit shifts, 32-bit arithmetic shift, selects, xor
    send(4'h9, 0, 1, 4'hF, {4{32'hF0F0_70F0}}, {4{32'h0004_0004}}, '0, {4{32'hFF0F_070F}});
    send(4'h8, 0, 0, 4'hF, {4{32'hF0F0_70F0}}, {4{32'h0004_0004}}, '0, {4{32'h0F00_0F00}});
    send(4'hA, 0, 1, 4'hF, {4{32'h1234_ABCD}}, {4{32'h0014_0018}}, '0, {4{32'h4123_CDAB}});
    send(4'h9, 1, 1, 4'hF, {4{32'h8000_0000}}, {4{32'h0000_0024}}, '0, {4{32'hF800_0000}});
    send(4'h5, 0, 0, 4'hF, {4{32'h4200_3C00}}, {4{32'h3C00_4200}}, {4{6'b100_001}},
         {4{32'h4200_4200}});
    send(4'h5, 1, 0, 4'hF, {4{32'h4200_3C00}}, {4{32'h3C00_4200}}, {4{6'b100_001}},
         {4{32'h3C00_4200}});
    send(4'h7, 1, 0, 4'hF, {4{32'h4200_3C00}}, {4{32'h3C00_4200}}, {4{6'b100_001}},
         {4{32'h4200_3C00}});
    send(4'h2, 1, 0, 4'hF, V_A, V_B, '0,
         {32'hFF00_FF00, 32'hEDCB_5678, 32'hF00F_F00F, 32'h2152_4110});
    wait_drain();

    // back-pressure: capacity equals latency, then in-order drain
    out_rdy_i = 1'b0;
    accepts = 0;
    op_i = 4'h4; prec_i = 1'b1; lane_en_i = 4'hF; in_vld_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      src0_i = bp_vec(accepts);
      @(negedge clk);
      if (in_rdy_o) begin
        exp_q.push_back(bp_vec(accepts));
        accepts++;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_accepts", 128'(accepts), 128'(2));
    @(negedge clk);
    chk("bp_in_rdy", 128'(in_rdy_o), 128'(0));
    chk("bp_hold_vld", 128'(out_vld_o), 128'(1));
    chk("bp_hold_dst", dst_o, bp_vec(0));
    @(posedge clk);
    #1;
    in_vld_i = 1'b0;
    out_rdy_i = 1'b1;
    wait_drain();

    // illegal opcode, then masked lanes with err staying set
    send(4'hC, 1, 0, 4'hF, {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, '0, '0);
    chk("err_set", 128'(err_o), 128'(1));
    send(4'h0, 1, 0, 4'b0101, V_A, V_B, '0,
         {32'h0, 32'h1234_0000, 32'h0, 32'hDEAD_BEEF});
    wait_drain();
    chk("err_sticky", 128'(err_o), 128'(1));

    // reset with two ops in flight
    out_rdy_i = 1'b0;
    send(4'h4, 1, 0, 4'hF, {4{32'h1111_1111}}, '0, '0, {4{32'h1111_1111}});
    send(4'h4, 1, 0, 4'hF, {4{32'h2222_2222}}, '0, '0, {4{32'h2222_2222}});
    rst_n = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    out_rdy_i = 1'b1;
    seen_vld = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_vld_o) seen_vld = 1;
    end
    chk("flush_no_vld", 128'(seen_vld), 128'(0));
    chk("flush_cnt", 128'(op_cnt_o), 128'(0));
    chk("flush_err", 128'(err_o), 128'(0));
    @(posedge clk);
    #1;

    // 17 handshakes on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      send(4'h4, 1, 0, 4'hF, {4{32'h0000_0100 + 32'(i)}}, '0, '0, {4{32'h0000_0100 + 32'(i)}});
    end
    wait_drain();
    chk("cnt_wrap", 128'(op_cnt_o), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
